// File: rtl/r4_sdf_stage_ctrl.sv
// Sequencer for one radix-4 SDF FFT stage: frame counter, strobes, twiddle addressing and output sequencing.
// Define R4_CTRL_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module r4_sdf_stage_ctrl #(
    parameter int STAGE_LOG2 = 2,
    parameter int TW_AW      = STAGE_LOG2 + 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  flush,
    output logic [1:0]            phase,
    output logic [STAGE_LOG2-1:0] idx,
    output logic                  dl_wr_en,
    output logic                  bf_en,
    output logic [TW_AW-1:0]      tw0_addr,
    output logic [TW_AW-1:0]      tw1_addr,
    output logic [TW_AW-1:0]      tw2_addr,
    output logic [1:0]            out_sel,
    output logic                  out_valid,
    output logic                  out_last,
`ifdef R4_CTRL_FRAME_CNT_EN
    output logic [15:0]           frame_cnt,
`endif
    output logic                  busy
);

    localparam int CW = STAGE_LOG2 + 2;
    localparam int D  = 1 << STAGE_LOG2;
    localparam logic [CW-1:0]         CNT_FILL_END = CW'(3 * D - 1);
    localparam logic [CW-1:0]         CNT_LAST     = CW'(4 * D - 1);
    localparam logic [STAGE_LOG2-1:0] IDX_LAST     = '1;

    typedef enum logic [1:0] {IDLE, FILL, COMPUTE, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  pending_q, pending_d;
    logic [1:0]            phase_q, phase_d;
    logic [STAGE_LOG2-1:0] idx_q, idx_d;
    logic                  dlWr_q, dlWr_d;
    logic                  bfEn_q, bfEn_d;
    logic [TW_AW-1:0]      tw0_q, tw0_d, tw1_q, tw1_d, tw2_q, tw2_d;
    logic [1:0]            outSel_q, outSel_d;
    logic                  outValid_q, outValid_d;
    logic                  outLast_q, outLast_d;
    logic                  busy_q, busy_d;

    logic [1:0]            quarter;
    logic [STAGE_LOG2-1:0] cntIdx;
    logic [TW_AW-1:0]      twBase;

    assign quarter = cnt_q[CW-1 -: 2];
    assign cntIdx  = cnt_q[STAGE_LOG2-1:0];
    assign twBase  = TW_AW'(cntIdx);

    // In DRAIN, cnt_q is reused as the drain position (0..3D-1) over the pending frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pending_q  <= 1'b0;
            phase_q    <= '0;
            idx_q      <= '0;
            dlWr_q     <= 1'b0;
            bfEn_q     <= 1'b0;
            tw0_q      <= '0;
            tw1_q      <= '0;
            tw2_q      <= '0;
            outSel_q   <= '0;
            outValid_q <= 1'b0;
            outLast_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            phase_q    <= phase_d;
            idx_q      <= idx_d;
            dlWr_q     <= dlWr_d;
            bfEn_q     <= bfEn_d;
            tw0_q      <= tw0_d;
            tw1_q      <= tw1_d;
            tw2_q      <= tw2_d;
            outSel_q   <= outSel_d;
            outValid_q <= outValid_d;
            outLast_q  <= outLast_d;
            busy_q     <= busy_d;
        end
    end

    // Pending marks a computed frame whose out1..out3 have not all been emitted yet.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pending_d = pending_q;
        if (state_q == DRAIN) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_FILL_END) begin
                state_d   = IDLE;
                cnt_d     = '0;
                pending_d = 1'b0;
            end
        end else if (in_valid) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
                state_d   = FILL;
                pending_d = 1'b1;
            end else if (cnt_q == CNT_FILL_END) begin
                state_d   = COMPUTE;
                pending_d = 1'b0;
            end else begin
                state_d = (quarter == 2'd3) ? COMPUTE : FILL;
            end
        end else if (flush && state_q != IDLE) begin
            cnt_d   = '0;
            state_d = pending_q ? DRAIN : IDLE;
        end
    end

    always_comb begin
        phase_d    = phase_q;
        idx_d      = idx_q;
        dlWr_d     = 1'b0;
        bfEn_d     = 1'b0;
        tw0_d      = '0;
        tw1_d      = '0;
        tw2_d      = '0;
        outSel_d   = '0;
        outValid_d = 1'b0;
        if (state_q == DRAIN) begin
            phase_d    = quarter;
            idx_d      = cntIdx;
            outValid_d = 1'b1;
            outSel_d   = quarter + 2'd1;
        end else if (in_valid) begin
            phase_d = quarter;
            idx_d   = cntIdx;
            if (quarter == 2'd3) begin
                bfEn_d     = 1'b1;
                outValid_d = 1'b1;
                tw0_d      = twBase;
                tw1_d      = twBase << 1;
                tw2_d      = twBase + (twBase << 1);
            end else begin
                dlWr_d = 1'b1;
                if (pending_q) begin
                    outValid_d = 1'b1;
                    outSel_d   = quarter + 2'd1;
                end
            end
        end
        outLast_d = outValid_d && (outSel_d == 2'd3) && (idx_d == IDX_LAST);
        busy_d    = (state_d != IDLE);
    end

`ifdef R4_CTRL_FRAME_CNT_EN
    logic [15:0] frameCnt_q;
    logic        frameTick;

    assign frameTick = ((state_q == COMPUTE) && (state_d == FILL)) ||
                       ((state_q == DRAIN) && (state_d == IDLE));

    always_ff @(posedge clk) begin
        if (rst)
            frameCnt_q <= '0;
        else if (frameTick)
            frameCnt_q <= frameCnt_q + 16'd1;
    end

    assign frame_cnt = frameCnt_q;
`endif

    assign phase     = phase_q;
    assign idx       = idx_q;
    assign dl_wr_en  = dlWr_q;
    assign bf_en     = bfEn_q;
    assign tw0_addr  = tw0_q;
    assign tw1_addr  = tw1_q;
    assign tw2_addr  = tw2_q;
    assign out_sel   = outSel_q;
    assign out_valid = outValid_q;
    assign out_last  = outLast_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_r4_sdf_stage_ctrl.sv
// Self-checking bench for r4_sdf_stage_ctrl (D=4): directed scenarios plus random traffic,
// compared every cycle against a sample-position reference model.
module tb_r4_sdf_stage_ctrl;

    localparam int STAGE_LOG2 = 2;
    localparam int TW_AW      = STAGE_LOG2 + 2;
    localparam int D          = 1 << STAGE_LOG2;
    localparam int L          = 4 * D;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  in_valid = 1'b0;
    logic                  flush = 1'b0;
    logic [1:0]            phase;
    logic [STAGE_LOG2-1:0] idx;
    logic                  dl_wr_en;
    logic                  bf_en;
    logic [TW_AW-1:0]      tw0_addr, tw1_addr, tw2_addr;
    logic [1:0]            out_sel;
    logic                  out_valid;
    logic                  out_last;
    logic                  busy;
`ifdef R4_CTRL_FRAME_CNT_EN
    logic [15:0]           frame_cnt;
`endif

    int assertCount = 0;
    int failCount   = 0;

    // Reference model: position in frame, whether a computed frame still owes outputs, drain progress.
    int mPos = 0;
    int mDrainPos = 0;
    bit mPend = 1'b0;
    bit mActive = 1'b0;
    bit mDraining = 1'b0;
`ifdef R4_CTRL_FRAME_CNT_EN
    int mFc = 0;
`endif
    int ePhase, eIdx, eDl, eBf, eTw0, eTw1, eTw2, eSel, eValid, eLast, eBusy;

    r4_sdf_stage_ctrl #(.STAGE_LOG2(STAGE_LOG2), .TW_AW(TW_AW)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .flush(flush),
        .phase(phase),
        .idx(idx),
        .dl_wr_en(dl_wr_en),
        .bf_en(bf_en),
        .tw0_addr(tw0_addr),
        .tw1_addr(tw1_addr),
        .tw2_addr(tw2_addr),
        .out_sel(out_sel),
        .out_valid(out_valid),
        .out_last(out_last),
`ifdef R4_CTRL_FRAME_CNT_EN
        .frame_cnt(frame_cnt),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, observed, expected);
        end
    endtask

    // Predicts the registered outputs produced by the edge that samples (r, v, f).
    task automatic modelStep(input bit r, input bit v, input bit f);
        int q;
        int i;
        eDl = 0; eBf = 0; eTw0 = 0; eTw1 = 0; eTw2 = 0; eSel = 0; eValid = 0; eLast = 0;
        if (r) begin
            mPos = 0; mPend = 0; mActive = 0; mDraining = 0; mDrainPos = 0;
            ePhase = 0; eIdx = 0;
`ifdef R4_CTRL_FRAME_CNT_EN
            mFc = 0;
`endif
        end else if (mDraining) begin
            q = mDrainPos / D;
            i = mDrainPos % D;
            ePhase = q; eIdx = i; eValid = 1; eSel = q + 1;
            eLast = (mDrainPos == 3 * D - 1) ? 1 : 0;
            mDrainPos++;
            if (mDrainPos == 3 * D) begin
                mDraining = 0; mPend = 0; mPos = 0;
`ifdef R4_CTRL_FRAME_CNT_EN
                mFc = (mFc + 1) % 65536;
`endif
            end
        end else if (v) begin
            q = mPos / D;
            i = mPos % D;
            ePhase = q; eIdx = i;
            if (q == 3) begin
                eBf = 1; eValid = 1; eTw0 = i; eTw1 = 2 * i; eTw2 = 3 * i;
            end else begin
                eDl = 1;
                if (mPend) begin
                    eValid = 1;
                    eSel = q + 1;
                    eLast = (q == 2 && i == D - 1) ? 1 : 0;
                end
                if (q == 2 && i == D - 1) mPend = 0;
            end
            if (mPos == L - 1) begin
                mPend = 1;
`ifdef R4_CTRL_FRAME_CNT_EN
                mFc = (mFc + 1) % 65536;
`endif
            end
            mPos = (mPos + 1) % L;
            mActive = 1;
        end else if (f && mActive) begin
            mActive = 0;
            mPos = 0;
            if (mPend) begin
                mDraining = 1;
                mDrainPos = 0;
            end
        end
        eBusy = (mActive || mDraining) ? 1 : 0;
    endtask

    task automatic compareAll();
        checkOutput("phase", phase, ePhase);
        checkOutput("idx", idx, eIdx);
        checkOutput("dl_wr_en", dl_wr_en, eDl);
        checkOutput("bf_en", bf_en, eBf);
        checkOutput("tw0_addr", tw0_addr, eTw0);
        checkOutput("tw1_addr", tw1_addr, eTw1);
        checkOutput("tw2_addr", tw2_addr, eTw2);
        checkOutput("out_sel", out_sel, eSel);
        checkOutput("out_valid", out_valid, eValid);
        checkOutput("out_last", out_last, eLast);
        checkOutput("busy", busy, eBusy);
`ifdef R4_CTRL_FRAME_CNT_EN
        checkOutput("frame_cnt", frame_cnt, mFc);
`endif
    endtask

    // One clock: drive inputs, advance the model, check every output just after the edge.
    task automatic applyStimulus(input bit r, input bit v, input bit f);
        rst = r;
        in_valid = v;
        flush = f;
        modelStep(r, v, f);
        @(posedge clk);
        #1;
        compareAll();
    endtask

    task automatic runSamples(input int n);
        repeat (n) applyStimulus(1'b0, 1'b1, 1'b0);
    endtask

    task automatic flushAndIdle(input int idleCycles);
        applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (idleCycles) applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bit r;
        bit v;
        bit f;
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);

        // Two full frames back to back, then drain the second.
        runSamples(32);
        flushAndIdle(14);

        // Single frame, drain, then idle checks busy dropping.
        runSamples(16);
        flushAndIdle(14);

        // Gap of three cycles at position 5.
        runSamples(5);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
        runSamples(27);
        flushAndIdle(14);

        // Reset at position 9 of frame 2, then a fresh frame.
        runSamples(25);
        applyStimulus(1'b1, 1'b1, 1'b0);
        runSamples(16);
        flushAndIdle(14);

        // Flush together with in_valid is ignored.
        repeat (32) applyStimulus(1'b0, 1'b1, 1'b1);
        flushAndIdle(14);

        // Flush mid-frame with nothing pending goes straight to idle.
        runSamples(7);
        flushAndIdle(3);

        // in_valid during DRAIN is dropped.
        runSamples(16);
        applyStimulus(1'b0, 1'b0, 1'b1);
        runSamples(20);
        flushAndIdle(14);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(0, 99) < 2);
            v = ($urandom_range(0, 99) < 70);
            f = ($urandom_range(0, 99) < 8);
            applyStimulus(r, v, f);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/r4_sdf_stage_ctrl.md
R4_SDF_STAGE_CTRL -- requirements
Module: r4_sdf_stage_ctrl

Interface
REQ-001 SHALL have parameter STAGE_LOG2, default 2, log2 of stage span D (frame length L = 4*D).
REQ-002 SHALL have parameter TW_AW, default STAGE_LOG2+2, twiddle ROM address width.
REQ-003 SHALL have a single clock and a synchronous, active-high reset: clk input 1 rising-edge clock; rst input 1 synchronous active-high reset.
REQ-004 SHALL have in_valid input 1: a sample is accepted this cycle.
REQ-005 SHALL have flush input 1: end of stream, drain pending outputs.
REQ-006 SHALL have phase output 2: quarter of frame for the accepted sample.
REQ-007 SHALL have idx output STAGE_LOG2: position within quarter.
REQ-008 SHALL have dl_wr_en output 1: delay lines capture the input (phases 0-2).
REQ-009 SHALL have bf_en output 1: butterfly operands valid (phase 3).
REQ-010 SHALL have tw0_addr, tw1_addr, tw2_addr outputs TW_AW each: twiddle indices for b, c, d.
REQ-011 SHALL have out_sel output 2: which butterfly output (out0..out3) is emitted.
REQ-012 SHALL have out_valid output 1 and out_last output 1: emitted sample valid / last sample of a frame.
REQ-013 SHALL have busy output 1: state is not IDLE.

Function
REQ-014 SHALL keep a frame counter cnt of STAGE_LOG2+2 bits, with phase = cnt[MSB:MSB-1] and idx = cnt low bits, advancing only on accepted samples and wrapping L-1 -> 0.
REQ-015 SHALL register all outputs, so strobes for the sample accepted in cycle t appear in cycle t+1.
REQ-016 SHALL force all strobes (dl_wr_en, bf_en, out_valid, out_last) to 0 in any cycle following in_valid=0 outside DRAIN, holding counters.
REQ-017 SHALL implement states IDLE, FILL (phases 0-2), COMPUTE (phase 3) and DRAIN.
REQ-018 SHALL transition IDLE->FILL on in_valid, FILL->COMPUTE when cnt reaches 3D, and COMPUTE->FILL when cnt wraps to 0.
REQ-019 SHALL, in FILL, assert dl_wr_en; if a previous frame is pending, assert out_valid with out_sel = phase+1.
REQ-020 SHALL, in COMPUTE, assert bf_en and out_valid with out_sel=0, drive tw0_addr=idx, tw1_addr=2*idx, tw2_addr=3*idx (no truncation, max 3(D-1) < L), and set the pending flag at the last COMPUTE cycle.
REQ-021 SHALL hold twiddle addresses at 0 outside COMPUTE.
REQ-022 SHALL assert out_last with out_valid when out_sel=3 and idx=D-1.
REQ-023 SHALL, on flush with in_valid=0 and pending=1, enter DRAIN and emit 3D samples on consecutive cycles (out_sel 1,2,3, idx 0..D-1) regardless of in_valid, then go to IDLE and clear pending and cnt.
REQ-024 SHALL ignore flush when in_valid=1 in the same cycle; the sample is accepted.
REQ-025 SHALL, on flush mid-frame (cnt != 0), discard the partial frame; with pending=0, go directly to IDLE.
REQ-026 SHALL ignore in_valid during DRAIN; the sample is dropped and cnt is unchanged.

Reset
REQ-027 SHALL, on rst, go to IDLE next edge with cnt=0, pending=0, and all outputs 0, including mid-frame or mid-DRAIN.

Configuration
REQ-028 SHALL, when R4_CTRL_FRAME_CNT_EN is defined, add output frame_cnt (16 bits, reset 0) that increments at each COMPUTE->FILL wrap or DRAIN->IDLE exit and wraps at 65535->0.
REQ-029 SHALL, without R4_CTRL_FRAME_CNT_EN, not have the frame_cnt port or logic.

Verification
REQ-030 SHALL cover (D=4) 16 consecutive in_valid -> dl_wr_en for cycles 1-12, bf_en for 13-16, tw1_addr 0,2,4,6, and out_valid only in COMPUTE.
REQ-031 SHALL cover 32 consecutive in_valid -> cycles 17-28 out_valid with out_sel 1,1,1,1,2,...,3, and out_last at cycle 28.
REQ-032 SHALL cover 16 samples then flush -> 12 DRAIN cycles out_valid, out_last on the 12th, then busy=0.
REQ-033 SHALL cover in_valid gaps at cnt=5 for 3 cycles -> phase/idx frozen, strobes 0, and sequence resumes identically.
REQ-034 SHALL cover rst asserted at cnt=9 of frame 2 -> all outputs 0 next cycle, and the next frame restarts at phase 0 with out_valid only in COMPUTE.
REQ-035 SHALL cover flush with in_valid=1 together -> sample accepted, no DRAIN entry; with R4_CTRL_FRAME_CNT_EN, frame_cnt=2 after 32 samples.
